// File: rtl/eclock_vpa_ctrl.sv
// eclock_vpa_ctrl: derives the 6800-style E clock from C7M and runs the VPA/VMA handshake.
module eclock_vpa_ctrl #(
  parameter int E_PERIOD  = 10,
  parameter int E_HIGH    = 4,
  parameter int VMA_POINT = 3
) (
  input  logic       C14M,
  input  logic       RESET,
  input  logic       C7M,
  input  logic       AS_n,
  input  logic       VPA_n,
  output logic       E,
  output logic       VMA_n,
  output logic       ECYC_END,
  output logic [3:0] ECNT
);
  localparam logic [3:0] LP_LAST = 4'(E_PERIOD - 1);
  localparam logic [3:0] LP_RISE = 4'(E_PERIOD - E_HIGH);
  localparam logic [3:0] LP_VMA  = 4'(VMA_POINT);
  typedef enum logic [1:0] {IDLE, SYNC, VMA, DONE} state_t;
  state_t     r_state;
  logic [3:0] r_ecnt;
  logic       r_e, r_vma_n, r_end;
  logic       w_tick;
  logic [3:0] w_ecnt_nxt;
  assign w_tick     = ~C7M;
  assign w_ecnt_nxt = (r_ecnt == LP_LAST) ? 4'd0 : r_ecnt + 4'd1;
  // The E counter free-runs; the handshake only observes it.
  always_ff @(posedge C14M or posedge RESET) begin
    if (RESET) begin
      r_ecnt <= 4'd0;
      r_e    <= 1'b0;
    end else if (w_tick) begin
      r_ecnt <= w_ecnt_nxt;
      r_e    <= w_ecnt_nxt >= LP_RISE;
    end
  end
  always_ff @(posedge C14M or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_vma_n <= 1'b1;
      r_end   <= 1'b0;
    end else begin
      r_end <= 1'b0;
      case (r_state)
        IDLE: begin
          r_vma_n <= 1'b1;
          if (!AS_n && !VPA_n) r_state <= SYNC;
        end
        SYNC: begin
          if (AS_n) begin
            r_vma_n <= 1'b1;
            r_state <= IDLE;
          end else if (w_tick && w_ecnt_nxt == LP_VMA) begin
            r_vma_n <= 1'b0;
            r_state <= VMA;
          end
        end
        VMA: begin
          if (AS_n) begin
            r_vma_n <= 1'b1;
            r_state <= IDLE;
          end else if (w_tick && w_ecnt_nxt == 4'd0) begin
            r_end   <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          if (AS_n) begin
            r_vma_n <= 1'b1;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
  assign E        = r_e;
  assign VMA_n    = r_vma_n;
  assign ECYC_END = r_end;
  assign ECNT     = r_ecnt;
endmodule

// File: tb/tb_eclock_vpa_ctrl.sv
// tb_eclock_vpa_ctrl: random stimulus against a tick-counting reference model of the E clock and VMA handshake.
module tb_eclock_vpa_ctrl;
  localparam int P = 10, H = 4, V = 3;
  logic       C14M = 0, RESET = 1, C7M = 0, AS_n = 1, VPA_n = 1;
  logic       E, VMA_n, ECYC_END;
  logic [3:0] ECNT;
  int n_chk = 0, n_err = 0;
  eclock_vpa_ctrl #(.E_PERIOD(P), .E_HIGH(H), .VMA_POINT(V)) dut (
    .C14M(C14M), .RESET(RESET), .C7M(C7M), .AS_n(AS_n), .VPA_n(VPA_n),
    .E(E), .VMA_n(VMA_n), .ECYC_END(ECYC_END), .ECNT(ECNT)
  );
  always #5 C14M = ~C14M;
  int m_ticks, m_st, m_nx;
  bit m_tk, m_vma_n, m_end;
  always @(posedge C14M or posedge RESET) begin
    if (RESET) begin
      m_ticks = 0; m_st = 0; m_vma_n = 1; m_end = 0;
    end else begin
      m_tk = !C7M;
      if (m_tk) m_ticks++;
      m_nx  = m_ticks % P;
      m_end = 0;
      if (m_st == 0) begin
        m_vma_n = 1;
        if (!AS_n && !VPA_n) m_st = 1;
      end else if (AS_n) begin
        m_st = 0; m_vma_n = 1;
      end else if (m_st == 1 && m_tk && m_nx == V) begin
        m_st = 2; m_vma_n = 0;
      end else if (m_st == 2 && m_tk && m_nx == 0) begin
        m_st = 3; m_end = 1;
      end
    end
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask
  int as_hold = 0, stuck = 0, rst_cnt = 0, n_end = 0;
  initial begin
    repeat (3) @(negedge C14M);
    chk("rst_e", E, 0); chk("rst_vma", VMA_n, 1); chk("rst_end", ECYC_END, 0); chk("rst_ecnt", ECNT, 0);
    RESET = 0; C7M = 0; AS_n = 0; VPA_n = 1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge C14M);
      chk("ecnt", ECNT, m_ticks % P);
      chk("e", E, int'((m_ticks % P) >= P - H));
      chk("vma_n", VMA_n, m_vma_n);
      chk("ecyc_end", ECYC_END, m_end);
      n_end += int'(ECYC_END);
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) begin RESET = 0; C7M = 0; end
        continue;
      end
      if (cyc > 60 && $urandom_range(399) == 0) begin
        RESET = 1; C7M = 0; AS_n = 1; stuck = 0;
        #1;
        chk("arst_e", E, 0); chk("arst_vma", VMA_n, 1); chk("arst_end", ECYC_END, 0); chk("arst_ecnt", ECNT, 0);
        rst_cnt = $urandom_range(3, 1);
        continue;
      end
      if (stuck > 0) begin
        stuck--; C7M = 1;
      end else begin
        C7M = ~C7M;
        if ($urandom_range(199) == 0) stuck = $urandom_range(20, 4);
      end
      if (cyc < 60) begin
        AS_n = 0; VPA_n = 1;
      end else begin
        if (as_hold == 0) begin
          AS_n = ~AS_n;
          as_hold = AS_n ? $urandom_range(8, 1) : $urandom_range(50, 3);
        end else as_hold--;
        if ($urandom_range(9) == 0) VPA_n = $urandom_range(3) == 0;
      end
    end
    chk("some_ecyc_end", int'(n_end > 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
